// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Brief    : Decodes 16-bit instructions into registered datapath controls and
//            sequences the multi-cycle LOAD and REPEAT instructions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [12:0] ControlWord,
  output logic [3:0]  ConstantIn,
  output logic [3:0]  DataIn,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_REPEAT    = 2'd2
  } state_t;

  localparam logic [1:0] C_CLS_REG  = 2'b00;
  localparam logic [1:0] C_CLS_IMM  = 2'b01;
  localparam logic [1:0] C_CLS_LOAD = 2'b10;
  localparam logic [1:0] C_CLS_REP  = 2'b11;

  state_t      r_state, w_state_nxt;
  logic [12:0] r_cw, w_cw_nxt;
  logic [3:0]  r_const, w_const_nxt;
  logic [3:0]  r_data, w_data_nxt;
  logic [3:0]  r_count, w_count_nxt;
  logic [1:0]  r_load_da, w_load_da_nxt;
  logic        r_done, w_done_nxt;

  logic [1:0]  w_class;
  logic [3:0]  w_fs;
  logic [1:0]  w_da, w_aa, w_ba;
  logic [3:0]  w_imm;
  logic        w_accept;
  logic [12:0] w_reg_cw;

  assign w_class  = instr[15:14];
  assign w_fs     = instr[13:10];
  assign w_da     = instr[9:8];
  assign w_aa     = instr[7:6];
  assign w_ba     = instr[5:4];
  assign w_imm    = instr[3:0];
  assign w_reg_cw = {w_da, w_aa, w_ba, 1'b0, w_fs, 1'b0, 1'b1};

  assign instr_ready = (r_state == S_IDLE) && !RST;
  assign data_ready  = (r_state == S_WAIT_DATA);
  assign w_accept    = instr_valid && instr_ready;

  assign ControlWord = r_cw;
  assign ConstantIn  = r_const;
  assign DataIn      = r_data;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cw      <= 13'h0;
      r_const   <= 4'h0;
      r_data    <= 4'h0;
      r_count   <= 4'h0;
      r_load_da <= 2'b00;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cw      <= w_cw_nxt;
      r_const   <= w_const_nxt;
      r_data    <= w_data_nxt;
      r_count   <= w_count_nxt;
      r_load_da <= w_load_da_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Idle cycles drop RW but keep the other control fields stable.
  always_comb begin
    w_state_nxt   = r_state;
    w_cw_nxt      = {r_cw[12:1], 1'b0};
    w_const_nxt   = r_const;
    w_data_nxt    = r_data;
    w_count_nxt   = r_count;
    w_load_da_nxt = r_load_da;
    w_done_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_class)
            C_CLS_REG: begin
              w_cw_nxt   = w_reg_cw;
              w_done_nxt = 1'b1;
            end
            C_CLS_IMM: begin
              w_cw_nxt    = {w_da, w_aa, w_ba, 1'b1, w_fs, 1'b0, 1'b1};
              w_const_nxt = w_imm;
              w_done_nxt  = 1'b1;
            end
            C_CLS_LOAD: begin
              w_load_da_nxt = w_da;
              w_state_nxt   = S_WAIT_DATA;
            end
            C_CLS_REP: begin
              w_cw_nxt    = w_reg_cw;
              w_count_nxt = w_imm;
              if (w_imm == 4'h0) begin
                w_done_nxt = 1'b1;
              end else begin
                w_state_nxt = S_REPEAT;
              end
            end
            default: ;
          endcase
        end
      end

      S_WAIT_DATA: begin
        if (data_valid) begin
          w_data_nxt  = data_in;
          w_cw_nxt    = {r_load_da, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b1};
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_REPEAT: begin
        // The accept cycle issued the first write; each cycle here issues one more.
        w_cw_nxt = {r_cw[12:1], 1'b1};
        if (r_count <= 4'h1) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_count_nxt = r_count - 4'h1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Directed scoreboard bench for control_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] instr = 16'h0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  data_in = 4'h0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [12:0] ControlWord;
  logic [3:0]  ConstantIn;
  logic [3:0]  DataIn;
  logic        busy;
  logic        done;

  control_sequencer dut (
    .CLK         (CLK),
    .RST         (RST),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .ControlWord (ControlWord),
    .ConstantIn  (ConstantIn),
    .DataIn      (DataIn),
    .busy        (busy),
    .done        (done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [12:0] cw;
    logic [3:0]  k;
    logic [3:0]  d;
    logic        dn;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic push(input logic [12:0] cw, input logic [3:0] k, input logic [3:0] d,
                      input logic dn);
    exp_t e;
    e.cw = cw; e.k = k; e.d = d; e.dn = dn;
    q.push_back(e);
  endtask

  // Monitor: every datapath write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (!RST) begin
        if (ControlWord[0] === 1'b1) begin
          if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got cw=%h expected no write", ControlWord);
          end else begin
            e = q.pop_front();
            chk("write_cw",    {3'b0, ControlWord}, {3'b0, e.cw});
            chk("write_const", {12'b0, ConstantIn}, {12'b0, e.k});
            chk("write_data",  {12'b0, DataIn},     {12'b0, e.d});
            chk("write_done",  {15'b0, done},       {15'b0, e.dn});
          end
        end else if (done !== 1'b0) begin
          n_total++;
          $display("FAIL stray_done: got done=%b expected 0 with RW=0", done);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_cw",    {3'b0, ControlWord}, 16'h0);
    chk("rst_busy",  {15'b0, busy},       16'h0);
    chk("rst_ready", {15'b0, instr_ready}, 16'h0);
    RST = 1'b0;
    #1;
    chk("rst_ready_release", {15'b0, instr_ready}, 16'h1);

    // IMM class01 FS=0010 DA=1 IMM=5
    instr = 16'h4905; instr_valid = 1'b1;
    push(13'h0849, 4'h5, 4'h0, 1'b1);
    @(negedge CLK);
    instr_valid = 1'b0;
    @(negedge CLK);
    chk("imm_idle_rw",   {15'b0, ControlWord[0]}, 16'h0);
    chk("imm_idle_done", {15'b0, done},           16'h0);
    chk("imm_idle_hold", {3'b0, ControlWord},     16'h0848);

    // Asynchronous reset asserted mid-cycle
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    chk("async_rst_cw",    {3'b0, ControlWord}, 16'h0);
    chk("async_rst_const", {12'b0, ConstantIn}, 16'h0);
    chk("async_rst_busy",  {15'b0, busy},       16'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("async_rst_ready", {15'b0, instr_ready}, 16'h1);

    // Three back-to-back REG instructions
    instr = 16'h1670; instr_valid = 1'b1;
    push(13'h1395, 4'h0, 4'h0, 1'b1);
    @(negedge CLK);
    chk("b2b_ready1", {15'b0, instr_ready}, 16'h1);
    instr = 16'h20E0;
    push(13'h0721, 4'h0, 4'h0, 1'b1);
    @(negedge CLK);
    chk("b2b_ready2", {15'b0, instr_ready}, 16'h1);
    instr = 16'h07C0;
    push(13'h1E05, 4'h0, 4'h0, 1'b1);
    @(negedge CLK);
    instr_valid = 1'b0;

    // LOAD DA=3, data withheld for four cycles
    instr = 16'h8300; instr_valid = 1'b1;
    @(negedge CLK);
    instr_valid = 1'b0;
    chk("load_cw_hold", {3'b0, ControlWord}, 16'h1E04);
    for (int i = 0; i < 4; i++) begin
      chk("load_wait_data_ready", {15'b0, data_ready},     16'h1);
      chk("load_wait_instr_rdy",  {15'b0, instr_ready},    16'h0);
      chk("load_wait_rw",         {15'b0, ControlWord[0]}, 16'h0);
      chk("load_wait_busy",       {15'b0, busy},           16'h1);
      @(negedge CLK);
    end
    data_in = 4'hA; data_valid = 1'b1;
    push(13'h1803, 4'h0, 4'hA, 1'b1);
    @(negedge CLK);
    data_valid = 1'b0;
    chk("load_end_busy",       {15'b0, busy},       16'h0);
    chk("load_end_data_ready", {15'b0, data_ready}, 16'h0);

    // data_valid while idle must not disturb DataIn
    data_in = 4'h7; data_valid = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
    chk("stray_data_hold", {12'b0, DataIn}, 16'h000A);

    // REPEAT FS=0001 DA=AA=2 IMM=3 -> four writes, decoy instruction held meanwhile
    instr = 16'hC683; instr_valid = 1'b1;
    push(13'h1405, 4'h0, 4'hA, 1'b0);
    push(13'h1405, 4'h0, 4'hA, 1'b0);
    push(13'h1405, 4'h0, 4'hA, 1'b0);
    push(13'h1405, 4'h0, 4'hA, 1'b1);
    @(negedge CLK);
    instr = 16'h4905;
    for (int i = 0; i < 3; i++) begin
      chk("rep_ready_low", {15'b0, instr_ready}, 16'h0);
      @(negedge CLK);
    end
    instr_valid = 1'b0;
    @(negedge CLK);

    // REPEAT IMM=7 interrupted by reset after two writes
    instr = 16'hC957; instr_valid = 1'b1;
    push(13'h0A89, 4'h0, 4'hA, 1'b0);
    push(13'h0A89, 4'h0, 4'hA, 1'b0);
    @(negedge CLK);
    instr_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rep_rst_cw",   {3'b0, ControlWord}, 16'h0);
    chk("rep_rst_done", {15'b0, done},       16'h0);
    chk("rep_rst_busy", {15'b0, busy},       16'h0);
    chk("rep_rst_data", {12'b0, DataIn},     16'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rep_rst_ready", {15'b0, instr_ready}, 16'h1);
    chk("rep_rst_queue", q.size()[15:0],       16'h0);

    // REPEAT with IMM=0 is a single write with done
    instr = 16'hCDB0; instr_valid = 1'b1;
    push(13'h0D8D, 4'h0, 4'h0, 1'b1);
    @(negedge CLK);
    instr_valid = 1'b0;
    chk("rep0_busy", {15'b0, busy}, 16'h0);
    repeat (3) @(negedge CLK);
    chk("final_queue_empty", q.size()[15:0], 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
